// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode and FSM state encodings,
// flag bit positions and a helper that assembles the flag vector.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Place overflow, negative and zero into their flag-vector positions.
  function automatic logic [2:0] pack_flags(input logic v, input logic n, input logic z);
    logic [2:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/add_sub_w.sv
// W-bit adder/subtractor with two's-complement overflow.
// Overflow is the carry into the MSB XOR the carry out of the MSB.
module add_sub_w #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] b_eff;
  logic [W-2:0] low_sum;
  logic         carry_msb;
  logic         carry_out;
  logic         msb_sum;

  // Subtraction is a + ~b + 1; the +1 enters as the carry-in of the low part.
  assign b_eff = sub ? ~b : b;

  assign {carry_msb, low_sum} = {1'b0, a[W-2:0]} + {1'b0, b_eff[W-2:0]}
                              + {{(W-1){1'b0}}, sub};

  assign {carry_out, msb_sum} = {1'b0, a[W-1]} + {1'b0, b_eff[W-1]} + {1'b0, carry_msb};

  assign sum = {msb_sum, low_sum};
  assign ovf = carry_msb ^ carry_out;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops finish on the
// accepting edge; MUL runs a shift-add loop, one multiplier bit per cycle.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W   = 64,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  output logic         busy
);

  localparam int CW = SHW + 1;

  state_e         state_reg;
  state_e         state_next;
  logic           accept;
  logic           is_mul;
  logic           mul_last;

  // Single-cycle datapath
  logic [W-1:0]   as_sum;
  logic           as_ovf;
  logic [W-1:0]   sc_result;
  logic           sc_v;

  // Shift-add multiplier datapath
  logic [W-1:0]   mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] acc_next;
  logic [W:0]     part_sum;
  logic [CW-1:0]  cnt_reg;

  assign accept   = in_valid && (state_reg == S_IDLE);
  assign is_mul   = (op_e'(op) == OP_MUL);
  assign mul_last = (state_reg == S_MUL) && (cnt_reg == CW'(1));

  add_sub_w #(.W(W)) u_add_sub (
    .a   (a),
    .b   (b),
    .sub (op_e'(op) == OP_SUB),
    .sum (as_sum),
    .ovf (as_ovf)
  );

  // Result and overflow for the ops that complete on the accepting edge.
  always_comb begin
    sc_result = '0;
    sc_v      = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_SUB: begin
        sc_result = as_sum;
        sc_v      = as_ovf;
      end
      OP_AND:  sc_result = a & b;
      OP_NOT:  sc_result = ~b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_SLL:  sc_result = a << b[SHW-1:0];
      default: sc_result = '0;
    endcase
  end

  // One multiply step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    part_sum = {1'b0, acc_reg[2*W-1:W]} + {1'b0, (mplier_reg[0] ? mcand_reg : {W{1'b0}})};
    acc_next = {part_sum, acc_reg[W-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_last) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, multiply iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result     <= '0;
      flags      <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand_reg  <= a;
        mplier_reg <= b;
        acc_reg    <= '0;
        cnt_reg    <= CW'(W);
      end else begin
        result <= sc_result;
        flags  <= pack_flags(sc_v, sc_result[W-1], sc_result == '0);
      end
    end else if (state_reg == S_MUL) begin
      mplier_reg <= mplier_reg >> 1;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_reg - CW'(1);
      if (mul_last) begin
        result <= acc_next[W-1:0];
        flags  <= pack_flags(|acc_next[2*W-1:W], acc_next[W-1], acc_next[W-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at W=16: directed vector table, randomized
// ops against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_mc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [2:0]    flags;
  logic          busy;

  int total = 0;
  int bad   = 0;

  alu_mc #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: returns {V,N,Z,result}.
  function automatic logic [18:0] ref_model(input logic [2:0] o, input logic [15:0] x,
                                            input logic [15:0] y);
    int          sx;
    int          sy;
    int          s;
    longint      p;
    logic [15:0] r;
    logic        v;
    sx = $signed(x);
    sy = $signed(y);
    s  = 0;
    p  = 0;
    r  = '0;
    v  = 1'b0;
    case (o)
      3'd0: begin s = sx + sy; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sx - sy; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd2: r = x & y;
      3'd3: r = ~y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = x << (y % 16);
      default: begin
        p = longint'(x) * longint'(y);
        r = 16'(p);
        v = (p >> 16) != 0;
      end
    endcase
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  // Issue one op, measure latency, hold out_ready low for 'hold' cycles while
  // driving junk requests, then complete the handshake and confirm nothing queued.
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input int hold, output logic [15:0] r, output logic [2:0] f,
                        output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op        = o;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b1;
      op       = 3'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
    end while (!out_valid && lat < 100);
    check("out_valid_seen", 32'(out_valid), 32'd1);
    r = result;
    f = flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", 32'(result), 32'(r));
      check("hold_flags", 32'(flags), 32'(f));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
    $display("op=%0d a=%h b=%h -> result=%h flags=%b lat=%0d hold=%0d", o, x, y, r, f, lat, hold);
  endtask

  initial begin
    logic [15:0] r;
    logic [2:0]  f;
    logic [18:0] m;
    int          lat;
    int          seen;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1};
    vecs[1]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b001, 1};
    vecs[2]  = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 3'b101, 17};
    vecs[3]  = '{3'd7, 16'h00FF, 16'h0003, 16'h02FD, 3'b000, 17};
    vecs[4]  = '{3'd6, 16'h0001, 16'h0013, 16'h0008, 3'b000, 1};
    vecs[5]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b000, 1};
    vecs[6]  = '{3'd3, 16'h1234, 16'h0000, 16'hFFFF, 3'b010, 1};
    vecs[7]  = '{3'd4, 16'h8000, 16'h0001, 16'h8001, 3'b010, 1};
    vecs[8]  = '{3'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b001, 1};
    vecs[9]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1};
    vecs[10] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b001, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors (junk requests and a 3-cycle stall on each)
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 3, r, f, lat);
      check("vec_result", 32'(r), 32'(vecs[i].res));
      check("vec_flags", 32'(f), 32'(vecs[i].fl));
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra;
      logic [15:0] rb;
      ro = 3'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) rb = 16'($urandom_range(0, 3));
      m = ref_model(ro, ra, rb);
      run_op(ro, ra, rb, int'($urandom_range(0, 3)), r, f, lat);
      check("rnd_result", 32'(r), 32'(m[15:0]));
      check("rnd_flags", 32'(f), 32'(m[18:16]));
      check("rnd_latency", 32'(lat), (ro == 3'd7) ? 32'd17 : 32'd1);
    end

    // Reset five cycles into a MUL abandons it
    @(negedge clk);
    op       = 3'd7;
    a        = 16'h1234;
    b        = 16'h00FF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mul_busy", 32'(busy), 32'd1);
    check("mul_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    $display("reset-abort: out_valid pulses after release=%0d", seen);

    // A normal op still works after the abort
    run_op(3'd7, 16'h0003, 16'h0005, 1, r, f, lat);
    check("after_abort_result", 32'(r), 32'h000F);
    check("after_abort_latency", 32'(lat), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter W, default 64: operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(W): shift-amount width, derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-007 SHALL have port op, input, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 NOT(b), 100 OR, 101 XOR, 110 SLL, 111 MUL.
REQ-008 SHALL have ports a and b, input, W bits each: operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port result, output, W bits: operation result.
REQ-012 SHALL have port flags, output, 3 bits: [2] overflow V, [1] negative N, [0] zero Z.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both high, capturing op, a and b.
REQ-015 SHALL implement FSM states IDLE, MUL, DONE; in_ready SHALL equal (state==IDLE).
REQ-016 SHALL move IDLE->DONE on accepting a single-cycle op (ADD..SLL), so out_valid rises on the first edge after acceptance.
REQ-017 SHALL move IDLE->MUL on accepting MUL, iterate shift-add one multiplier bit per cycle for exactly W cycles, then move MUL->DONE; out_valid rises W+1 edges after acceptance.
REQ-018 SHALL hold result, flags and out_valid stable in DONE until out_ready is high, then move DONE->IDLE on that edge.
REQ-019 SHALL compute ADD/SUB modulo 2^W, with V equal to the signed two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-020 SHALL compute SLL as a shifted left by b[SHW-1:0], ignoring upper bits of b, zero-filled.
REQ-021 SHALL return the low W bits of the unsigned 2W-bit product for MUL, with V=1 when the upper W bits are non-zero.
REQ-022 SHALL force V=0 for AND, NOT, OR, XOR and SLL.
REQ-023 SHALL set N=result[W-1] and Z=(result==0) for every op.
REQ-024 SHALL ignore in_valid, op, a and b changes while not in IDLE; no request is queued.
REQ-025 SHALL NOT drop a result while out_ready is low, however long it stays low.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, flags=000, busy=0 and clear the MUL iteration counter and accumulator.
REQ-027 SHALL abandon any in-progress MUL or pending DONE result on reset, producing no out_valid after release.
REQ-028 SHALL drive in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-029 SHALL place the op encoding, the FSM state enum and the flag bit indices (FLAG_V=2, FLAG_N=1, FLAG_Z=0) in shared package alu_mc_pkg.
REQ-030 SHALL instantiate one sub-module add_sub_w, parametrised by W, providing sum/difference and the V flag for ADD/SUB.
REQ-031 SHALL implement the MUL datapath as a W-bit multiplicand shift register, a W-bit multiplier shift register, a 2W-bit accumulator and a SHW+1-bit down-counter.

Verification (W=16)
REQ-032 SHALL check ADD a=0x7FFF b=0x0001 -> result 0x8000, flags 110, out_valid one edge after acceptance.
REQ-033 SHALL check SUB a=0x0005 b=0x0005 -> result 0x0000, flags 001.
REQ-034 SHALL check MUL a=0x0100 b=0x0100 -> result 0x0000, flags 101, out_valid exactly 17 edges after acceptance; and MUL 0x00FF*0x0003 -> 0x02FD, flags 000.
REQ-035 SHALL check SLL a=0x0001 b=0x0013 -> result 0x0008, flags 000, confirming upper shift bits are ignored.
REQ-036 SHALL check that holding out_ready low for 3 cycles after out_valid keeps result/flags stable and in_ready=0, and a new in_valid is ignored until the handshake completes.
REQ-037 SHALL check that asserting rst_n low 5 cycles into a MUL gives out_valid=0 and busy=0 immediately, with no result after release and in_ready=1 on the next edge.
